// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchronises the line, validates start bits mid-bit, deserialises
// LSB first and holds each good byte on a valid/ready output, flagging framing errors and overruns.
module uart_rx_byte #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       UART_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;
   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [2:0]             bit_idx_q, bit_idx_d;
   logic [7:0]             shreg_q, shreg_d;
   logic [7:0]             data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;
   logic                   ovr_q, ovr_d;

   // Line idles high, so the chain resets to 1s to avoid a false start out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], UART_rx};
      end
   end

   assign rxs = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      data_d    = data_q;
      valid_d   = valid_q;
      ferr_d    = 1'b0;
      ovr_d     = 1'b0;

      if (valid_q && rx_ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (!rxs) begin
               state_d = StStart;
               cnt_d   = '0;
            end
         end
         StStart: begin
            if (cnt_q == HalfLast) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rxs ? StIdle : StData;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StData: begin
            if (cnt_q == BitLast) begin
               cnt_d              = '0;
               shreg_d[bit_idx_q] = rxs;
               bit_idx_d          = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StStop: begin
            if (cnt_q == BitLast) begin
               cnt_d = '0;
               if (rxs) begin
                  state_d = StIdle;
                  // An accept on this same edge frees the slot for the new byte.
                  if (!valid_q || rx_ready) begin
                     data_d  = shreg_q;
                     valid_d = 1'b1;
                  end else begin
                     ovr_d = 1'b1;
                  end
               end else begin
                  ferr_d  = 1'b1;
                  state_d = StWaitHigh;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWaitHigh: begin
            if (rxs) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy      = (state_q != StIdle);
      rx_data   = data_q;
      rx_valid  = valid_q;
      frame_err = ferr_q;
      overrun   = ovr_q;
   end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: drives 8N1 frames and compares accepted bytes, flags and timing
// against expectations derived from the frame contents and the handshake rules.
module tb_uart_rx_byte;

   localparam int C    = 16;
   localparam int SYNC = 2;
   localparam int LAT  = SYNC + 1 + C / 2 + 9 * C;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       UART_rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int tests_run = 0;
   int failed = 0;

   uart_rx_byte #(
      .CLKS_PER_BIT(C),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .UART_rx  (UART_rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observer: accepted bytes, flag pulses and output-stability violations.
   logic [7:0] got_q[$];
   int   ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0, stab_cnt = 0, valid_cycles = 0;
   int   last_rise = -1;
   logic prev_valid = 1'b0, prev_acc = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(negedge clk) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_valid) valid_cycles++;
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_err && overrun) both_cnt++;
      if (rx_valid && !prev_valid) last_rise = cyc;
      if (prev_valid && rx_valid && !prev_acc && rx_data !== prev_data) stab_cnt++;
      prev_valid = rx_valid;
      prev_data  = rx_data;
      prev_acc   = rx_valid && rx_ready;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic v, input int n);
      UART_rx = v;
      step(n);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      drive(1'b0, C);
      for (int i = 0; i < 8; i++) drive(b[i], C);
      drive(stop_bit, C);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      tests_run++; if (rx_data !== 8'h00) begin failed++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
      tests_run++; if (rx_valid !== 1'b0) begin failed++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
      tests_run++; if ({frame_err, overrun} !== 2'b00) begin failed++; $display("FAIL reset_flags got %b%b exp 00", frame_err, overrun); end
      tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b exp 0", busy); end
      step(4);
   endtask

   task automatic test_single();
      int g0, v0, f0, o0, fall;
      g0 = got_q.size(); v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
      rx_ready = 1'b1;
      fall = cyc;
      send_frame(8'hA5, 1'b1);
      drive(1'b1, C);
      tests_run++; if (got_q.size() != g0 + 1) begin failed++; $display("FAIL single_count got %0d exp 1", got_q.size() - g0); end
      else begin
         tests_run++; if (got_q[g0] !== 8'hA5) begin failed++; $display("FAIL single_data got %h exp a5", got_q[g0]); end
      end
      tests_run++; if (last_rise - fall != LAT) begin failed++; $display("FAIL single_latency got %0d exp %0d", last_rise - fall, LAT); end
      tests_run++; if (valid_cycles - v0 != 1) begin failed++; $display("FAIL single_valid_width got %0d exp 1", valid_cycles - v0); end
      tests_run++; if (ferr_cnt != f0 || ovr_cnt != o0) begin failed++; $display("FAIL single_flags got %0d/%0d exp 0/0", ferr_cnt - f0, ovr_cnt - o0); end
   endtask

   task automatic test_back_to_back(input int n, input bit rand_bytes, input bit rand_gap);
      logic [7:0] exp_q[$];
      logic [7:0] b;
      int g0, v0, f0, o0;
      g0 = got_q.size(); v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
      rx_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (rand_bytes) b = 8'($urandom);
         else b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h3C;
         exp_q.push_back(b);
         send_frame(b, 1'b1);
         if (rand_gap) drive(1'b1, $urandom_range(0, C));
      end
      drive(1'b1, C);
      tests_run++; if (got_q.size() != g0 + n) begin failed++; $display("FAIL b2b_count got %0d exp %0d", got_q.size() - g0, n); end
      else begin
         for (int i = 0; i < n; i++) begin
            tests_run++; if (got_q[g0 + i] !== exp_q[i]) begin failed++; $display("FAIL b2b_data[%0d] got %h exp %h", i, got_q[g0 + i], exp_q[i]); end
         end
      end
      tests_run++; if (valid_cycles - v0 != n) begin failed++; $display("FAIL b2b_valid_cycles got %0d exp %0d", valid_cycles - v0, n); end
      tests_run++; if (ferr_cnt != f0 || ovr_cnt != o0) begin failed++; $display("FAIL b2b_flags got %0d/%0d exp 0/0", ferr_cnt - f0, ovr_cnt - o0); end
   endtask

   task automatic test_overrun(input int n, input bit rand_bytes);
      logic [7:0] first;
      logic [7:0] b;
      int g0, o0, f0;
      g0 = got_q.size(); o0 = ovr_cnt; f0 = ferr_cnt;
      rx_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         b = rand_bytes ? 8'($urandom) : ((i == 0) ? 8'h11 : 8'h22);
         if (i == 0) first = b;
         send_frame(b, 1'b1);
      end
      drive(1'b1, C);
      tests_run++; if (rx_valid !== 1'b1) begin failed++; $display("FAIL ovr_valid_held got %b exp 1", rx_valid); end
      tests_run++; if (rx_data !== first) begin failed++; $display("FAIL ovr_data_held got %h exp %h", rx_data, first); end
      tests_run++; if (ovr_cnt - o0 != n - 1) begin failed++; $display("FAIL ovr_pulses got %0d exp %0d", ovr_cnt - o0, n - 1); end
      tests_run++; if (ferr_cnt != f0) begin failed++; $display("FAIL ovr_ferr got %0d exp 0", ferr_cnt - f0); end
      rx_ready = 1'b1;
      step(1);
      tests_run++; if (rx_valid !== 1'b0) begin failed++; $display("FAIL ovr_accept_drop got %b exp 0", rx_valid); end
      tests_run++; if (got_q.size() != g0 + 1 || got_q[got_q.size() - 1] !== first) begin
         failed++; $display("FAIL ovr_accepted got %0d bytes exp 1 byte %h", got_q.size() - g0, first);
      end
      step(2);
   endtask

   task automatic test_frame_err();
      int g0, f0, o0;
      g0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
      rx_ready = 1'b1;
      send_frame(8'h55, 1'b0);
      drive(1'b0, 40);
      tests_run++; if (busy !== 1'b1) begin failed++; $display("FAIL ferr_busy_low got %b exp 1", busy); end
      drive(1'b1, C);
      send_frame(8'h81, 1'b1);
      drive(1'b1, C);
      tests_run++; if (ferr_cnt - f0 != 1) begin failed++; $display("FAIL ferr_pulses got %0d exp 1", ferr_cnt - f0); end
      tests_run++; if (ovr_cnt != o0) begin failed++; $display("FAIL ferr_overrun got %0d exp 0", ovr_cnt - o0); end
      tests_run++; if (got_q.size() != g0 + 1 || got_q[got_q.size() - 1] !== 8'h81) begin
         failed++; $display("FAIL ferr_recovery got %0d bytes exp 1 byte 81", got_q.size() - g0);
      end
   endtask

   task automatic test_glitch();
      int g0, f0, o0;
      g0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
      drive(1'b0, 3);
      drive(1'b1, 4);
      tests_run++; if (busy !== 1'b1) begin failed++; $display("FAIL glitch_start got busy %b exp 1", busy); end
      drive(1'b1, 4);
      tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL glitch_busy_clear got %b exp 0", busy); end
      drive(1'b1, C);
      tests_run++; if (got_q.size() != g0 || ferr_cnt != f0 || ovr_cnt != o0) begin
         failed++; $display("FAIL glitch_side_effects got %0d/%0d/%0d exp 0/0/0", got_q.size() - g0, ferr_cnt - f0, ovr_cnt - o0);
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] b;
      int g0;
      rx_ready = 1'b0;
      send_frame(8'h5A, 1'b1);
      drive(1'b1, 4);
      g0 = got_q.size();
      b = 8'hC3;
      drive(1'b0, C);
      for (int i = 0; i < 4; i++) drive(b[i], C);
      drive(b[4], C / 2);
      rst = 1'b1;
      step(1);
      tests_run++; if ({rx_valid, frame_err, overrun, busy} !== 4'b0000 || rx_data !== 8'h00) begin
         failed++; $display("FAIL midreset_outputs got v%b f%b o%b b%b d%h exp all 0", rx_valid, frame_err, overrun, busy, rx_data);
      end
      rst = 1'b0;
      UART_rx = 1'b1;
      rx_ready = 1'b1;
      step(2 * C);
      send_frame(8'h7E, 1'b1);
      drive(1'b1, C);
      tests_run++; if (got_q.size() != g0 + 1 || got_q[got_q.size() - 1] !== 8'h7E) begin
         failed++; $display("FAIL midreset_recovery got %0d bytes exp 1 byte 7e", got_q.size() - g0);
      end
   endtask

   task automatic test_invariants();
      tests_run++; if (both_cnt != 0) begin failed++; $display("FAIL flags_together got %0d exp 0", both_cnt); end
      tests_run++; if (stab_cnt != 0) begin failed++; $display("FAIL data_stability got %0d exp 0", stab_cnt); end
   endtask

   initial begin
      step(1);
      test_reset();
      test_single();
      test_back_to_back(3, 1'b0, 1'b0);
      test_overrun(2, 1'b0);
      test_frame_err();
      test_glitch();
      test_mid_reset();
      test_back_to_back(6, 1'b1, 1'b1);
      test_overrun(int'($urandom_range(2, 4)), 1'b1);
      test_invariants();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
